// File: rtl/lat_tester_ctrl_pkg.sv
// Shared types for the latency tester: LT position codes, sequencer state encoding, result record.
// Also holds the result width and saturation constant used by the controller.
package lat_tester_ctrl_pkg;

  localparam int RES_W = 16;
  localparam logic [RES_W-1:0] LAT_SAT = '1;

  // Position codes match the generator's existing latency-tester box placement
  typedef enum logic [1:0] {
    LT_POS_NONE        = 2'b00,
    LT_POS_TOPLEFT     = 2'b01,
    LT_POS_CENTER      = 2'b10,
    LT_POS_BOTTOMRIGHT = 2'b11
  } lt_pos_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARM     = 2'b01,
    ST_MEASURE = 2'b10,
    ST_HOLD    = 2'b11
  } lt_state_t;

  typedef struct packed {
    logic [RES_W-1:0] lat_us;
    logic             timeout;
    logic             err;
  } lt_result_t;

endpackage

// File: rtl/lat_tester_ctrl_if.sv
// Host/OSD side of the latency tester: command inputs and the completed-result record.
// No backpressure: start is a one-cycle request, results are held until the next accepted start.
interface lat_tester_ctrl_if;
  import lat_tester_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic [1:0]       mode_sel;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [RES_W-1:0] lat_us;
  logic             timeout;
  logic             err;

  modport master (
    output start, abort, mode_sel,
    input  busy, done, result_valid, lat_us, timeout, err
  );

  modport slave (
    input  start, abort, mode_sel,
    output busy, done, result_valid, lat_us, timeout, err
  );

endinterface

// File: rtl/lat_tester_ctrl_sensor_filt.sv
// Photodiode input: 2-FF synchronizer then a run-length filter; sensor_lit changes after FILT_LEN agreeing samples.
// Latency 2+FILT_LEN cycles from a sensor_n change; no backpressure.
module lt_sensor_filt #(
  parameter int FILT_LEN = 4
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic sensor_n,
  output logic sensor_lit
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic       sync1;
  logic       sync2;
  logic [3:0] run_cnt;
  logic       lit_smp;

  assign lit_smp = ~sync2;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      run_cnt    <= 4'd0;
      sensor_lit <= 1'b0;
    end else begin
      sync1 <= sensor_n;
      sync2 <= sync1;
      // Any sample agreeing with the current state restarts the run
      if (lit_smp == sensor_lit) begin
        run_cnt <= 4'd0;
      end else if (run_cnt >= CNT_LAST) begin
        sensor_lit <= lit_smp;
        run_cnt    <= 4'd0;
      end else begin
        run_cnt <= run_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/lat_tester_ctrl.sv
// Latency-test sequencer: arms the LT pattern, times frame start to sensor light in us, then holds the pattern off.
// Outputs registered, 1-cycle response to start/abort/detection; no backpressure, results held until next start.
module lat_tester_ctrl
  import lat_tester_ctrl_pkg::*;
#(
  parameter int CLK_PER_US  = 27,
  parameter int FILT_LEN    = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int ARM_FRAMES  = 8
) (
  input  logic                    clk27,
  input  logic                    reset_n,
  lat_tester_ctrl_if.slave        host,
  input  logic                    vsync_in,
  input  logic                    sensor_n,
  output logic                    lt_active,
  output logic [1:0]              lt_mode
);

  localparam int PRESC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_US - 1);
  localparam logic [3:0]         ARM_LAST  = 4'(ARM_FRAMES - 1);
  localparam logic [3:0]         HOLD_LAST = 4'(HOLD_FRAMES - 1);

  lt_state_t          state_q, state_nxt;
  lt_pos_t            mode_q, mode_nxt;
  logic [PRESC_W-1:0] presc_q, presc_nxt;
  logic [RES_W-1:0]   us_q, us_nxt;
  logic [3:0]         arm_q, arm_nxt;
  logic [3:0]         hold_q, hold_nxt;
  lt_result_t         res_q, res_nxt;
  logic               rv_q, rv_nxt;
  logic               done_q, done_nxt;
  logic               lta_q, lta_nxt;
  logic               vs_q;
  logic               fs_q;
  logic               sensor_lit;

  lt_sensor_filt #(
    .FILT_LEN (FILT_LEN)
  ) u_sensor_filt (
    .clk27      (clk27),
    .reset_n    (reset_n),
    .sensor_n   (sensor_n),
    .sensor_lit (sensor_lit)
  );

  // Frame start: registered 1->0 edge of the negative-polarity vsync
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      vs_q <= vsync_in;
      fs_q <= vs_q & ~vsync_in;
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= LT_POS_NONE;
      presc_q <= '0;
      us_q    <= '0;
      arm_q   <= 4'd0;
      hold_q  <= 4'd0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
      lta_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      mode_q  <= mode_nxt;
      presc_q <= presc_nxt;
      us_q    <= us_nxt;
      arm_q   <= arm_nxt;
      hold_q  <= hold_nxt;
      res_q   <= res_nxt;
      rv_q    <= rv_nxt;
      done_q  <= done_nxt;
      lta_q   <= lta_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    mode_nxt  = mode_q;
    presc_nxt = presc_q;
    us_nxt    = us_q;
    arm_nxt   = arm_q;
    hold_nxt  = hold_q;
    res_nxt   = res_q;
    rv_nxt    = rv_q;
    done_nxt  = 1'b0;

    if (host.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (host.start) begin
            state_nxt       = ST_ARM;
            mode_nxt        = lt_pos_t'(host.mode_sel);
            rv_nxt          = 1'b0;
            res_nxt.timeout = 1'b0;
            res_nxt.err     = 1'b0;
            arm_nxt         = 4'd0;
          end
        end
        ST_ARM: begin
          if (fs_q) begin
            if (!sensor_lit) begin
              state_nxt = ST_MEASURE;
              presc_nxt = '0;
              us_nxt    = '0;
            end else if (arm_q >= ARM_LAST) begin
              // Screen already lit frame after frame: measurement cannot start
              state_nxt = ST_HOLD;
              res_nxt   = '{lat_us: '0, timeout: 1'b0, err: 1'b1};
              rv_nxt    = 1'b1;
              done_nxt  = 1'b1;
              hold_nxt  = 4'd0;
            end else begin
              arm_nxt = arm_q + 4'd1;
            end
          end
        end
        ST_MEASURE: begin
          // Detection is tested first so it wins over saturation in the same cycle
          if (sensor_lit) begin
            state_nxt = ST_HOLD;
            res_nxt   = '{lat_us: us_q, timeout: 1'b0, err: 1'b0};
            rv_nxt    = 1'b1;
            done_nxt  = 1'b1;
            hold_nxt  = 4'd0;
          end else if (us_q == LAT_SAT) begin
            state_nxt = ST_HOLD;
            res_nxt   = '{lat_us: LAT_SAT, timeout: 1'b1, err: 1'b0};
            rv_nxt    = 1'b1;
            done_nxt  = 1'b1;
            hold_nxt  = 4'd0;
          end else if (presc_q >= PRESC_MAX) begin
            presc_nxt = '0;
            us_nxt    = us_q + RES_W'(1);
          end else begin
            presc_nxt = presc_q + PRESC_W'(1);
          end
        end
        ST_HOLD: begin
          if (fs_q) begin
            if (hold_q >= HOLD_LAST) begin
              state_nxt = ST_IDLE;
            end else begin
              hold_nxt = hold_q + 4'd1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    lta_nxt = (state_nxt == ST_ARM) || (state_nxt == ST_MEASURE);
  end

  assign lt_active         = lta_q;
  assign lt_mode           = mode_q;
  assign host.busy         = (state_q != ST_IDLE);
  assign host.done         = done_q;
  assign host.result_valid = rv_q;
  assign host.lat_us       = res_q.lat_us;
  assign host.timeout      = res_q.timeout;
  assign host.err          = res_q.err;

endmodule

// File: tb/tb_lat_tester_ctrl.sv
// Bench for lat_tester_ctrl: scoreboard of expected results checked on each done pulse, plus direct state checks.
// A second instance with a 1-cycle microsecond tick exercises counter saturation within a short run.
module tb_lat_tester_ctrl;
  import lat_tester_ctrl_pkg::*;

  localparam int FRAME  = 600;
  localparam int VS_LEN = 6;

  typedef struct {
    logic [15:0] lat;
    logic        to;
    logic        er;
    logic [1:0]  mode;
  } exp_t;

  logic       clk27 = 1'b0;
  logic       reset_n = 1'b1;
  logic       reset_n_to = 1'b1;
  logic       vsync_in = 1'b1;
  logic       sensor_n = 1'b1;
  logic       sensor_n_to = 1'b1;
  logic       lt_active, lt_active_to;
  logic [1:0] lt_mode, lt_mode_to;

  int n_cmp = 0;
  int n_err = 0;
  int fall_cnt = 0;
  int done_cnt = 0;
  int done_cnt_to = 0;
  logic vs_prev = 1'b1;
  logic done_prev = 1'b0;
  exp_t sb_q[$];
  exp_t sb_q_to[$];

  lat_tester_ctrl_if hif ();
  lat_tester_ctrl_if hif_to ();

  lat_tester_ctrl #(.CLK_PER_US(27), .FILT_LEN(4), .HOLD_FRAMES(2), .ARM_FRAMES(8)) u_dut (
    .clk27(clk27), .reset_n(reset_n), .host(hif), .vsync_in(vsync_in),
    .sensor_n(sensor_n), .lt_active(lt_active), .lt_mode(lt_mode)
  );

  lat_tester_ctrl #(.CLK_PER_US(1), .FILT_LEN(4), .HOLD_FRAMES(2), .ARM_FRAMES(8)) u_dut_to (
    .clk27(clk27), .reset_n(reset_n_to), .host(hif_to), .vsync_in(vsync_in),
    .sensor_n(sensor_n_to), .lt_active(lt_active_to), .lt_mode(lt_mode_to)
  );

  initial forever #5 clk27 = ~clk27;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk27);
    #1;
  endtask

  initial begin
    forever begin
      tick(FRAME - VS_LEN);
      vsync_in = 1'b0;
      tick(VS_LEN);
      vsync_in = 1'b1;
    end
  end

  always @(negedge clk27) begin
    if (vs_prev && !vsync_in) fall_cnt <= fall_cnt + 1;
    vs_prev <= vsync_in;
  end

  // Scoreboard for the main instance
  always @(negedge clk27) begin
    exp_t e;
    if (done_prev) chk("done_1cyc", hif.done, 1'b0);
    done_prev <= hif.done;
    if (hif.done) begin
      if (sb_q.size() == 0) begin
        chk("unexp_done", hif.done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("lat_us", hif.lat_us, e.lat);
        chk("timeout", hif.timeout, e.to);
        chk("err", hif.err, e.er);
        chk("rv_at_done", hif.result_valid, 1'b1);
        chk("lta_at_done", lt_active, 1'b0);
        chk("lt_mode", lt_mode, e.mode);
      end
      done_cnt <= done_cnt + 1;
    end
  end

  always @(negedge clk27) begin
    exp_t e;
    if (hif_to.done) begin
      if (sb_q_to.size() == 0) begin
        chk("to_unexp_done", hif_to.done, 1'b0);
      end else begin
        e = sb_q_to.pop_front();
        chk("to_lat_us", hif_to.lat_us, e.lat);
        chk("to_timeout", hif_to.timeout, e.to);
        chk("to_err", hif_to.err, e.er);
        chk("to_rv", hif_to.result_valid, 1'b1);
      end
      done_cnt_to <= done_cnt_to + 1;
    end
  end

  task automatic wait_fall(input int budget);
    int prev = fall_cnt;
    int n = 0;
    while (fall_cnt == prev && n < budget) begin
      tick(1);
      n++;
    end
    chk("fall_wait", fall_cnt, prev + 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int prev = done_cnt;
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, done_cnt, prev + 1);
  endtask

  task automatic sync_frame();
    wait_fall(FRAME + 20);
    tick(40);
  endtask

  task automatic pulse_start(input logic [1:0] mode);
    hif.mode_sel = mode;
    hif.start    = 1'b1;
    tick(1);
    hif.start    = 1'b0;
  endtask

  task automatic pulse_abort();
    hif.abort = 1'b1;
    tick(1);
    hif.abort = 1'b0;
  endtask

  task automatic main_seq();
    int d0;
    hif.start = 1'b0; hif.abort = 1'b0; hif.mode_sel = 2'd0;
    #2 reset_n = 1'b0;
    tick(3);
    chk("rst_lta", lt_active, 1'b0);
    chk("rst_mode", lt_mode, 2'd0);
    chk("rst_busy", hif.busy, 1'b0);
    chk("rst_done", hif.done, 1'b0);
    chk("rst_rv", hif.result_valid, 1'b0);
    chk("rst_lat", hif.lat_us, 16'd0);
    chk("rst_to", hif.timeout, 1'b0);
    chk("rst_err", hif.err, 1'b0);
    reset_n = 1'b1;
    tick(5);

    // Nominal 1000 us measurement, then HOLD behaviour
    sync_frame();
    sb_q.push_back('{16'd1000, 1'b0, 1'b0, LT_POS_CENTER});
    pulse_start(LT_POS_CENTER);
    @(negedge clk27);
    chk("start_lta", lt_active, 1'b1);
    chk("start_busy", hif.busy, 1'b1);
    chk("start_rv_clr", hif.result_valid, 1'b0);
    wait_fall(FRAME + 20);
    tick(27010);
    sensor_n = 1'b0;
    wait_done("done_1000", 100);
    tick(5);
    pulse_start(LT_POS_TOPLEFT);
    @(negedge clk27);
    chk("hold_start_lta", lt_active, 1'b0);
    chk("hold_start_mode", lt_mode, LT_POS_CENTER);
    chk("hold_start_busy", hif.busy, 1'b1);
    sensor_n = 1'b1;
    wait_fall(FRAME + 20);
    tick(20);
    chk("hold_fs1_busy", hif.busy, 1'b1);
    wait_fall(FRAME + 20);
    tick(20);
    chk("hold_fs2_busy", hif.busy, 1'b0);
    chk("idle_rv", hif.result_valid, 1'b1);
    chk("idle_lat", hif.lat_us, 16'd1000);

    // Short glitch ignored, later real detection; abort in HOLD keeps result
    sync_frame();
    sb_q.push_back('{16'd300, 1'b0, 1'b0, LT_POS_TOPLEFT});
    pulse_start(LT_POS_TOPLEFT);
    wait_fall(FRAME + 20);
    d0 = done_cnt;
    tick(2700);
    sensor_n = 1'b0;
    tick(3);
    sensor_n = 1'b1;
    tick(30);
    chk("glitch_lta", lt_active, 1'b1);
    chk("glitch_busy", hif.busy, 1'b1);
    chk("glitch_nodone", done_cnt, d0);
    tick(8110 - 2733);
    sensor_n = 1'b0;
    wait_done("done_300", 100);
    tick(3);
    pulse_abort();
    @(negedge clk27);
    chk("abort_hold_busy", hif.busy, 1'b0);
    chk("abort_hold_rv", hif.result_valid, 1'b1);
    chk("abort_hold_lat", hif.lat_us, 16'd300);
    sensor_n = 1'b1;
    tick(20);

    // Sensor lit before start: error after ARM_FRAMES frame starts
    sensor_n = 1'b0;
    tick(20);
    sync_frame();
    sb_q.push_back('{16'd0, 1'b0, 1'b1, LT_POS_BOTTOMRIGHT});
    pulse_start(LT_POS_BOTTOMRIGHT);
    wait_done("done_err", 8 * FRAME + 200);
    tick(2);
    pulse_abort();
    sensor_n = 1'b1;
    tick(20);

    // Abort in MEASURE, then abort colliding with start in IDLE
    sync_frame();
    pulse_start(LT_POS_CENTER);
    wait_fall(FRAME + 20);
    tick(500);
    d0 = done_cnt;
    pulse_abort();
    @(negedge clk27);
    chk("abort_lta", lt_active, 1'b0);
    chk("abort_busy", hif.busy, 1'b0);
    chk("abort_rv", hif.result_valid, 1'b0);
    sensor_n = 1'b0;
    tick(50);
    chk("abort_nodone", done_cnt, d0);
    sensor_n = 1'b1;
    tick(20);
    hif.start = 1'b1;
    hif.abort = 1'b1;
    tick(1);
    hif.start = 1'b0;
    hif.abort = 1'b0;
    @(negedge clk27);
    chk("abort_start_busy", hif.busy, 1'b0);
    chk("abort_start_lta", lt_active, 1'b0);

    // Asynchronous reset mid-measurement, then a clean measurement
    sync_frame();
    pulse_start(LT_POS_TOPLEFT);
    wait_fall(FRAME + 20);
    tick(500);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_lta", lt_active, 1'b0);
    chk("arst_mode", lt_mode, 2'd0);
    chk("arst_busy", hif.busy, 1'b0);
    chk("arst_done", hif.done, 1'b0);
    chk("arst_rv", hif.result_valid, 1'b0);
    chk("arst_lat", hif.lat_us, 16'd0);
    chk("arst_to", hif.timeout, 1'b0);
    chk("arst_err", hif.err, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    sync_frame();
    sb_q.push_back('{16'd100, 1'b0, 1'b0, LT_POS_TOPLEFT});
    pulse_start(LT_POS_TOPLEFT);
    wait_fall(FRAME + 20);
    tick(2710);
    sensor_n = 1'b0;
    wait_done("done_100", 100);
    tick(5);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  task automatic timeout_seq();
    int n = 0;
    hif_to.start = 1'b0; hif_to.abort = 1'b0; hif_to.mode_sel = 2'd0;
    #2 reset_n_to = 1'b0;
    tick(3);
    reset_n_to = 1'b1;
    tick(10);
    sb_q_to.push_back('{16'hFFFF, 1'b1, 1'b0, LT_POS_CENTER});
    hif_to.mode_sel = LT_POS_CENTER;
    hif_to.start    = 1'b1;
    tick(1);
    hif_to.start    = 1'b0;
    while (done_cnt_to == 0 && n < 68000) begin
      tick(1);
      n++;
    end
    chk("done_timeout", done_cnt_to, 1);
    tick(2);
    chk("to_rv_hold", hif_to.result_valid, 1'b1);
    chk("to_lta_off", lt_active_to, 1'b0);
  endtask

  initial begin
    fork
      main_seq();
      timeout_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
